// File: rtl/gpu_pkg.sv
// Shared definitions for the SIMT branch path: NZP bit positions, flush FSM
// state type and default datapath widths.
package gpu_pkg;

  localparam int unsigned NZP_N = 2;
  localparam int unsigned NZP_Z = 1;
  localparam int unsigned NZP_P = 0;

  localparam int unsigned DEF_NUM_LANES    = 4;
  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_ADDR_W       = 8;
  localparam int unsigned DEF_IMM_W        = 8;
  localparam int unsigned DEF_FLUSH_CYCLES = 2;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Signal bundle between decode/register-read, the branch resolve unit and fetch.
interface branch_resolve_unit_if
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_LANES = DEF_NUM_LANES,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned IMM_W     = DEF_IMM_W
);
  logic                        stall;
  logic                        cmp_en;
  logic                        cmp_signed;
  logic [NUM_LANES*DATA_W-1:0] rs_d;
  logic [NUM_LANES*DATA_W-1:0] rt_d;
  logic [NUM_LANES-1:0]        lane_active;
  logic                        br_en;
  logic [2:0]                  br_mask;
  logic                        br_abs;
  logic [IMM_W-1:0]            imm;
  logic [ADDR_W-1:0]           pc_in;
  logic [3*NUM_LANES-1:0]      nzp_val;
  logic [ADDR_W-1:0]           seq_pc;
  logic                        redirect;
  logic [ADDR_W-1:0]           redirect_pc;
  logic                        flush;
  logic                        busy;
  logic                        divergent;
  logic                        br_err;

  modport slave (
    input  stall, cmp_en, cmp_signed, rs_d, rt_d, lane_active,
           br_en, br_mask, br_abs, imm, pc_in,
    output nzp_val, seq_pc, redirect, redirect_pc, flush, busy,
           divergent, br_err
  );

  modport master (
    output stall, cmp_en, cmp_signed, rs_d, rt_d, lane_active,
           br_en, br_mask, br_abs, imm, pc_in,
    input  nzp_val, seq_pc, redirect, redirect_pc, flush, busy,
           divergent, br_err
  );
endinterface

// File: rtl/nzp_lane.sv
// One SIMT lane: rs/rt compare, NZP flag register and branch-take bit.
module nzp_lane
  import gpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              cmp_en,
  input  logic              cmp_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        br_mask,
  output logic [2:0]        nzp,
  output logic              take
);

  logic [2:0] cmp_res;
  logic       lt;
  logic       eq;

  always_comb begin
    cmp_res = '0;
    eq      = (a == b);
    lt      = cmp_signed ? ($signed(a) < $signed(b)) : (a < b);
    cmp_res[NZP_N] = lt;
    cmp_res[NZP_Z] = eq;
    cmp_res[NZP_P] = !lt && !eq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nzp <= '0;
    end else if (cmp_en && !stall) begin
      nzp <= cmp_res;
    end
  end

  // A compare issued alongside the branch is forwarded instead of the stored flags.
  assign take = |((cmp_en ? cmp_res : nzp) & br_mask);

endmodule

// File: rtl/branch_resolve_unit.sv
// Next-address / branch resolution for the SIMT core: per-lane NZP flags,
// uniform branch decision, registered redirect and a counted pipeline flush.
module branch_resolve_unit
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_LANES    = DEF_NUM_LANES,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned IMM_W        = DEF_IMM_W,
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input logic                  clk,
  input logic                  reset,
  branch_resolve_unit_if.slave bus
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [NUM_LANES-1:0]   take_vec;
  logic [NUM_LANES-1:0]   act_take;
  logic [3*NUM_LANES-1:0] nzp_all;
  logic                   any_active;
  logic                   all_take;
  logic                   mixed;
  logic [IMM_W-1:0]       imm_v;
  logic [ADDR_W-1:0]      target;

  fsm_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              redirect_q, redirect_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic              flush_q, flush_d;
  logic              divergent_q, divergent_d;
  logic              br_err_q, br_err_d;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    nzp_lane #(.DATA_W(DATA_W)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .stall      (bus.stall),
      .cmp_en     (bus.cmp_en),
      .cmp_signed (bus.cmp_signed),
      .a          (bus.rs_d[i*DATA_W +: DATA_W]),
      .b          (bus.rt_d[i*DATA_W +: DATA_W]),
      .br_mask    (bus.br_mask),
      .nzp        (nzp_all[i*3 +: 3]),
      .take       (take_vec[i])
    );
  end

  // Uniform decision: every active lane must agree; an empty mask never branches.
  always_comb begin
    act_take   = take_vec & bus.lane_active;
    any_active = |bus.lane_active;
    all_take   = any_active && (act_take == bus.lane_active);
    mixed      = any_active && (|act_take) && !all_take;
  end

  assign imm_v  = bus.imm;
  assign target = bus.br_abs ? ADDR_W'(imm_v)
                             : bus.pc_in + ADDR_W'($signed(imm_v));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    flush_d       = flush_q;
    divergent_d   = 1'b0;
    br_err_d      = br_err_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.stall) begin
          flush_d = 1'b0;
          if (bus.br_en) begin
            if (all_take) begin
              redirect_d    = 1'b1;
              redirect_pc_d = target;
              flush_d       = 1'b1;
              cnt_d         = CNT_W'(FLUSH_CYCLES - 1);
              if (FLUSH_CYCLES > 1) state_d = S_FLUSH;
            end else if (mixed) begin
              divergent_d = 1'b1;
            end
          end
        end
      end
      S_FLUSH: begin
        if (!bus.stall) begin
          if (bus.br_en) br_err_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            flush_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      divergent_q   <= 1'b0;
      br_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      divergent_q   <= divergent_d;
      br_err_q      <= br_err_d;
    end
  end

  assign bus.nzp_val     = nzp_all;
  assign bus.seq_pc      = bus.pc_in + ADDR_W'(1);
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.flush       = flush_q;
  assign bus.busy        = (state_q == S_FLUSH);
  assign bus.divergent   = divergent_q;
  assign bus.br_err      = br_err_q;

endmodule
